// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core SQI memory interface.
// Two SQI memories (low and high nibble of each word) run in lock-step;
// each moves one nibble per cycle.
package idli_pkg;

  localparam int SQI_NUM    = 2;
  localparam int SQI_MEM_LO = 0;
  localparam int SQI_MEM_HI = 1;

  typedef logic [3:0] sqi_data_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  localparam int SQI_ADDR_NIBBLES = 6;
  localparam int SQI_DUMMY_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_ctrl.sv
// SQI transaction sequencer for the paired low/high nibble memories.
// A word-addressed request becomes: command byte (2 cycles), 24-bit address
// (6 cycles), 2 dummy cycles on reads, then a data stream that runs until the
// requester raises i_stop.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req/i_wr/i_addr      request, sampled only in IDLE; o_ack pulses on accept
//   i_stop                 ends the transaction after the current DATA cycle
//   o_busy                 high outside IDLE
//   o_rd_valid/o_rd_data   read nibbles, passed through from i_sqi_in in DATA
//   o_wr_ready/i_wr_data   write nibbles, passed through to o_sqi_out in DATA
//   o_sqi_*                SQI pin controls and data, i_sqi_in from the memories
module idli_sqi_ctrl
  import idli_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req,
  input  logic                      i_wr,
  input  logic [15:0]               i_addr,
  input  logic                      i_stop,
  output logic                      o_ack,
  output logic                      o_busy,
  output logic                      o_rd_valid,
  output sqi_data_t [SQI_NUM-1:0]   o_rd_data,
  output logic                      o_wr_ready,
  input  sqi_data_t [SQI_NUM-1:0]   i_wr_data,
  output logic                      o_sqi_cs_n,
  output logic                      o_sqi_sck_en,
  output logic                      o_sqi_oe,
  output sqi_data_t [SQI_NUM-1:0]   o_sqi_out,
  input  sqi_data_t [SQI_NUM-1:0]   i_sqi_in
);

  sqi_state_t  state, state_d;
  logic [2:0]  cnt;
  logic        wr;
  logic [15:0] addr;

  logic [31:0] cmd_addr;
  logic [2:0]  nib_idx;
  sqi_data_t   nib;

  // Command and address share one nibble-indexed word, sent MSB first.
  assign cmd_addr = {(wr ? SQI_CMD_WRITE : SQI_CMD_READ), 8'h00, addr};
  assign nib_idx  = (state == CMD) ? (3'd7 - cnt) : (3'd5 - cnt);
  assign nib      = cmd_addr[nib_idx*4 +: 4];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      wr    <= 1'b0;
      addr  <= '0;
    end else begin
      state <= state_d;
      // cnt restarts on every state entry; it is only consulted in CMD,
      // ADDR and DUMMY so wrap-around in DATA is harmless.
      cnt   <= (state_d != state) ? 3'd0 : cnt + 3'd1;
      if (state == IDLE && i_req) begin
        wr   <= i_wr;
        addr <= i_addr;
      end
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (i_req) state_d = CMD;
      CMD:   if (cnt == 3'd1) state_d = ADDR;
      ADDR:  if (cnt == 3'(SQI_ADDR_NIBBLES - 1)) state_d = wr ? DATA : DUMMY;
      DUMMY: if (cnt == 3'(SQI_DUMMY_CYCLES - 1)) state_d = DATA;
      DATA:  if (i_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin controls come from registered state only; data paths are
  // combinational pass-throughs during DATA.
  always_comb begin
    o_ack        = 1'b0;
    o_busy       = 1'b1;
    o_rd_valid   = 1'b0;
    o_rd_data    = '0;
    o_wr_ready   = 1'b0;
    o_sqi_cs_n   = 1'b0;
    o_sqi_sck_en = 1'b1;
    o_sqi_oe     = 1'b0;
    o_sqi_out    = '0;
    unique case (state)
      IDLE: begin
        o_ack        = i_req;
        o_busy       = 1'b0;
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
      end
      CMD, ADDR: begin
        o_sqi_oe  = 1'b1;
        o_sqi_out = {nib, nib};
      end
      DUMMY: ;
      DATA: begin
        if (wr) begin
          o_wr_ready = 1'b1;
          o_sqi_oe   = 1'b1;
          o_sqi_out  = i_wr_data;
        end else begin
          o_rd_valid = 1'b1;
          o_rd_data  = i_sqi_in;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/idli_sqi_ctrl.md
# idli_sqi_ctrl

Sequencer for the two SQI memories (low-nibble and high-nibble) attached to the core. It takes a word-addressed read or write request and drives both memories in lock-step: command, 24-bit address, dummy cycles and then a data stream that continues until the requester stops it. It sits between the fetch/load-store logic and the SQI pins. Each cycle it moves one nibble per memory.

## Interface
Parameters:
- none; `SQI_NUM` (2) and the SQI types come from `idli_pkg`.

Ports:
- `i_clk`  in  1  core clock. Single clock domain.
- `i_rst`  in  1  reset. Synchronous and active-high.
- `i_req`  in  1  start a transaction. Sampled only in IDLE.
- `i_wr`  in  1  1 = write, 0 = read. Captured with `i_req`.
- `i_addr`  in  16  word address. Captured with `i_req`.
- `i_stop`  in  1  end the transaction after the current DATA cycle.
- `o_ack`  out  1  one-cycle pulse when a request is accepted.
- `o_busy`  out  1  high in every state except IDLE.
- `o_rd_valid`  out  1  `o_rd_data` is valid this cycle.
- `o_rd_data`  out  `SQI_NUM`×`sqi_data_t`  read nibbles: index `SQI_MEM_LO` and `SQI_MEM_HI`.
- `o_wr_ready`  out  1  `i_wr_data` is consumed this cycle.
- `i_wr_data`  in  `SQI_NUM`×`sqi_data_t`  write nibbles.
- `o_sqi_cs_n`  out  1  chip select, shared by both memories, active-low.
- `o_sqi_sck_en`  out  1  enables the SQI clock this cycle.
- `o_sqi_oe`  out  1  drive enable for the SQI data pins.
- `o_sqi_out`  out  `SQI_NUM`×`sqi_data_t`  nibbles driven to each memory.
- `i_sqi_in`  in  `SQI_NUM`×`sqi_data_t`  nibbles received from each memory.

## Operation
States and transitions:
- IDLE → CMD → ADDR → (DUMMY, reads only) → DATA → IDLE.
- A 3-bit counter `cnt` is cleared on every state entry.

IDLE:
- `cs_n`=1; `sck_en`=0; `oe`=0; `o_busy`=0.
- If `i_req`=1: pulse `o_ack`, latch `i_wr` and `i_addr`, go to CMD.

CMD (2 cycles):
- The command byte is driven high nibble first, with the same value on both memories.
- Commands: 0x03 read, 0x02 write.
- `oe`=1, `cs_n`=0, `sck_en`=1.

ADDR (6 cycles):
- The 24-bit address is {8'h00, addr}, driven MSB nibble first, with the same value on both memories.
- The byte address in each memory equals the word address.

DUMMY (2 cycles, reads only):
- `oe`=0 from the first DUMMY cycle (bus turnaround).
- `o_sqi_out` is don't-care.

DATA, read:
- `o_rd_valid`=1 and `o_rd_data`=`i_sqi_in` combinationally. `oe`=0.

DATA, write:
- `o_wr_ready`=1 and `o_sqi_out`=`i_wr_data`. `oe`=1.

Leaving DATA:
- If `i_stop`=1 in a DATA cycle, that cycle's transfer still completes, then the block goes to IDLE.
- The address keeps auto-incrementing inside the memories; no re-address is issued.

Word layout (decided):
- DATA cycle 2k carries LO=word[3:0], HI=word[7:4].
- DATA cycle 2k+1 carries LO=word[11:8], HI=word[15:12].
- The requester stops on an odd DATA cycle to stay word-aligned. The block does not enforce this.

## Timing
- Reset: the block is in IDLE on the cycle after the reset edge.
  - `o_sqi_cs_n`=1.
  - All other outputs are 0: `o_ack`, `o_busy`, `o_rd_valid`, `o_wr_ready`, `o_sqi_sck_en`, `o_sqi_oe`, `o_sqi_out`.
- Reset mid-transaction: the same reset values apply. CS deasserts at the next edge.
- Cycle schedule, request accepted at cycle T:
  - CMD at T+1..T+2.
  - ADDR at T+3..T+8.
  - Read: DUMMY at T+9..T+10, first `o_rd_valid` at T+11.
  - Write: first `o_wr_ready` at T+9.
- Stop: with `i_stop` at cycle S, the block is in IDLE at S+1 with `cs_n`=1.
  - The earliest new `o_ack` is at S+1.
  - This guarantees at least 1 cycle of CS high between transactions.
- `i_stop` outside DATA is ignored.
- `i_req` while busy is ignored. The requester must hold `i_req` until `o_ack`.
- The output control signals (`cs_n`, `oe`, `sck_en`) are decoded from registered state only.
- Data outputs pass through combinationally in DATA.

## Structure
- Add the following to `idli_pkg`:
  - `SQI_CMD_READ`=8'h03 and `SQI_CMD_WRITE`=8'h02.
  - `sqi_state_t` enum: IDLE, CMD, ADDR, DUMMY, DATA.
  - `SQI_ADDR_NIBBLES`=6 and `SQI_DUMMY_CYCLES`=2.
- Single module with no sub-modules.
  - The command/address nibble select is a small mux indexed by `cnt`.
  - The latched command+address form a 32-bit value, {cmd, 8'h00, addr}, indexed by nibble.

## Test plan
- Read addr 0x1234:
  - Expect `o_sqi_out` nibbles 0,3,0,0,1,2,3,4 at T+1..T+8 on both memories.
  - Expect `oe` low from T+9 and `o_rd_valid` first at T+11.
  - Model returns LO=A, HI=B → `o_rd_data`={B,A}.
- Write addr 0xFFFF with 4 DATA cycles, then `i_stop`:
  - Expect command nibbles 0,2 and address 0,0,F,F,F,F.
  - Expect `o_wr_ready` for 4 cycles with `i_wr_data` echoed on the pins.
  - Expect `cs_n` high the cycle after the stop.
- Back-to-back: `i_req` held continuously → second `o_ack` exactly 1 cycle after the stop, with `cs_n` high for exactly 1 cycle.
- `i_stop` asserted during ADDR, then dropped → ignored; DATA starts at T+11.
- `i_req` pulsed during DATA → no `o_ack`; the latched address is unchanged.
- `i_rst` asserted at T+5 → at T+6 `cs_n`=1 and all other outputs 0; the next `i_req` restarts cleanly at CMD.
